// File: rtl/decode_stage_if.sv
// Bus bundle between the IF/ID latch, register file, EX/MEM forwarding source and ID/EX consumer.
interface decode_stage_if #(parameter int CNT_W = 16);
  logic             ifid_valid;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_npc;
  logic [4:0]       rsel1;
  logic [4:0]       rsel2;
  logic [31:0]      rdat1;
  logic [31:0]      rdat2;
  logic             exmem_wen;
  logic [4:0]       exmem_wsel;
  logic [31:0]      exmem_wdat;
  logic             ex_stall;
  logic             flush;
  logic             ifid_stall;
  logic             idex_valid;
  logic [31:0]      idex_instr;
  logic [31:0]      idex_npc;
  logic [31:0]      idex_rdat1;
  logic [31:0]      idex_rdat2;
  logic [4:0]       idex_wsel;
  logic             idex_wen;
  logic             idex_memread;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output ifid_valid, ifid_instr, ifid_npc, rdat1, rdat2,
           exmem_wen, exmem_wsel, exmem_wdat, ex_stall, flush,
    input  rsel1, rsel2, ifid_stall, idex_valid, idex_instr, idex_npc,
           idex_rdat1, idex_rdat2, idex_wsel, idex_wen, idex_memread, bubble_cnt
  );

  modport slave (
    input  ifid_valid, ifid_instr, ifid_npc, rdat1, rdat2,
           exmem_wen, exmem_wsel, exmem_wdat, ex_stall, flush,
    output rsel1, rsel2, ifid_stall, idex_valid, idex_instr, idex_npc,
           idex_rdat1, idex_rdat2, idex_wsel, idex_wen, idex_memread, bubble_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode: register reads with EX/MEM forwarding, load-use hazard detection,
// and the ID/EX pipeline register with flush/stall/bubble control and a bubble counter.
module decode_stage #(
  parameter int CNT_W = 16
) (
  input logic          CLK,
  input logic          nRST,
  decode_stage_if.slave bus
);
  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [4:0]        sel,
    input logic [DATA_W-1:0] rf,
    input logic              wen,
    input logic [4:0]        wsel,
    input logic [DATA_W-1:0] wdat
  );
    return (wen && (wsel != 5'd0) && (wsel == sel)) ? wdat : rf;
  endfunction

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        wsel_dec;
  logic              no_write;
  logic              wen_dec;
  logic              memread_dec;
  logic              uses_rt;
  logic [DATA_W-1:0] opnd1;
  logic [DATA_W-1:0] opnd2;
  logic              hazard;

  logic              vld_p1;
  logic [DATA_W-1:0] instr_p1;
  logic [DATA_W-1:0] npc_p1;
  logic [DATA_W-1:0] rdat1_p1;
  logic [DATA_W-1:0] rdat2_p1;
  logic [4:0]        wsel_p1;
  logic              wen_p1;
  logic              memread_p1;
  logic [CNT_W-1:0]  bubble_cnt_q;

  assign op    = bus.ifid_instr[31:26];
  assign funct = bus.ifid_instr[5:0];
  assign rs    = bus.ifid_instr[25:21];
  assign rt    = bus.ifid_instr[20:16];
  assign rd    = bus.ifid_instr[15:11];

  assign wsel_dec    = (op == OP_RTYPE) ? rd : (op == OP_JAL) ? 5'd31 : rt;
  assign no_write    = (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) ||
                       ((op == OP_RTYPE) && (funct == FN_JR));
  assign wen_dec     = !no_write && (wsel_dec != 5'd0);
  assign memread_dec = (op == OP_LW);
  assign uses_rt     = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);

  assign bus.rsel1 = rs;
  assign bus.rsel2 = rt;

  // Writeback needs no path here: the register file writes on negedge, so rdat is already current.
  assign opnd1 = fwd_sel(rs, bus.rdat1, bus.exmem_wen, bus.exmem_wsel, bus.exmem_wdat);
  assign opnd2 = fwd_sel(rt, bus.rdat2, bus.exmem_wen, bus.exmem_wsel, bus.exmem_wdat);

  assign hazard = bus.ifid_valid && vld_p1 && memread_p1 && (wsel_p1 != 5'd0) &&
                  ((wsel_p1 == rs) || (uses_rt && (wsel_p1 == rt)));

  assign bus.ifid_stall = !bus.flush && (bus.ex_stall || hazard);

  // ---- ID/EX boundary ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_p1       <= 1'b0;
      instr_p1     <= '0;
      npc_p1       <= '0;
      rdat1_p1     <= '0;
      rdat2_p1     <= '0;
      wsel_p1      <= '0;
      wen_p1       <= 1'b0;
      memread_p1   <= 1'b0;
      bubble_cnt_q <= '0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
    end else if (bus.ex_stall) begin
      vld_p1 <= vld_p1;
    end else if (hazard) begin
      vld_p1       <= 1'b0;
      wen_p1       <= 1'b0;
      memread_p1   <= 1'b0;
      bubble_cnt_q <= sat_inc(bubble_cnt_q);
    end else begin
      vld_p1     <= bus.ifid_valid;
      instr_p1   <= bus.ifid_instr;
      npc_p1     <= bus.ifid_npc;
      rdat1_p1   <= opnd1;
      rdat2_p1   <= opnd2;
      wsel_p1    <= wsel_dec;
      wen_p1     <= wen_dec && bus.ifid_valid;
      memread_p1 <= memread_dec && bus.ifid_valid;
    end
  end

  assign bus.idex_valid   = vld_p1;
  assign bus.idex_instr   = instr_p1;
  assign bus.idex_npc     = npc_p1;
  assign bus.idex_rdat1   = rdat1_p1;
  assign bus.idex_rdat2   = rdat2_p1;
  assign bus.idex_wsel    = wsel_p1;
  assign bus.idex_wen     = wen_p1;
  assign bus.idex_memread = memread_p1;
  assign bus.bubble_cnt   = bubble_cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_decode_stage;
  logic CLK = 1'b0;
  logic nRST;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  decode_stage_if #(.CNT_W(16)) bus ();
  decode_stage_if #(.CNT_W(2))  bus_s ();

  decode_stage #(.CNT_W(16)) dut   (.CLK(CLK), .nRST(nRST), .bus(bus));
  decode_stage #(.CNT_W(2))  dut_s (.CLK(CLK), .nRST(nRST), .bus(bus_s));

  // Narrow-counter copy sees identical traffic so saturation is reachable quickly.
  assign bus_s.ifid_valid = bus.ifid_valid;
  assign bus_s.ifid_instr = bus.ifid_instr;
  assign bus_s.ifid_npc   = bus.ifid_npc;
  assign bus_s.rdat1      = bus.rdat1;
  assign bus_s.rdat2      = bus.rdat2;
  assign bus_s.exmem_wen  = bus.exmem_wen;
  assign bus_s.exmem_wsel = bus.exmem_wsel;
  assign bus_s.exmem_wdat = bus.exmem_wdat;
  assign bus_s.ex_stall   = bus.ex_stall;
  assign bus_s.flush      = bus.flush;

  typedef struct packed {
    logic [4:0] wsel;
    logic       wen;
    logic       memread;
    logic       uses_rt;
  } dec_t;

  // Behavioural model of the ID/EX contents
  logic        m_valid, m_wen, m_mr;
  logic [31:0] m_instr, m_npc, m_rd1, m_rd2;
  logic [4:0]  m_wsel;
  int          m_cnt, m_cnt_s;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    d.wsel = i[20:16]; d.wen = 1'b1; d.memread = 1'b0; d.uses_rt = 1'b0;
    case (i[31:26])
      6'h00: begin d.wsel = i[15:11]; d.uses_rt = 1'b1; d.wen = (i[5:0] != 6'h08); end
      6'h03: d.wsel = 5'd31;
      6'h02: d.wen = 1'b0;
      6'h04, 6'h05, 6'h2B: begin d.wen = 1'b0; d.uses_rt = 1'b1; end
      6'h23: d.memread = 1'b1;
      default: ;
    endcase
    if (d.wsel == 5'd0) d.wen = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] sel, input logic [31:0] rf);
    if (bus.exmem_wen && bus.exmem_wsel != 5'd0 && bus.exmem_wsel == sel) return bus.exmem_wdat;
    return rf;
  endfunction

  function automatic logic m_hazard();
    dec_t d;
    logic [4:0] rs, rt;
    d  = decode(bus.ifid_instr);
    rs = bus.ifid_instr[25:21];
    rt = bus.ifid_instr[20:16];
    return bus.ifid_valid && m_valid && m_mr && (m_wsel != 5'd0) &&
           ((m_wsel == rs) || (d.uses_rt && m_wsel == rt));
  endfunction

  function automatic logic exp_stall();
    return !bus.flush && (bus.ex_stall || m_hazard());
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wen = 0; m_mr = 0; m_instr = 0; m_npc = 0;
    m_rd1 = 0; m_rd2 = 0; m_wsel = 0; m_cnt = 0; m_cnt_s = 0;
  endtask

  // Advance the model by one edge using current inputs, then move past the DUT edge.
  task automatic tick();
    dec_t d;
    d = decode(bus.ifid_instr);
    if (bus.flush) begin
      m_valid = 1'b0;
    end else if (bus.ex_stall) begin
      m_valid = m_valid;
    end else if (m_hazard()) begin
      m_valid = 1'b0; m_wen = 1'b0; m_mr = 1'b0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end else begin
      m_valid = bus.ifid_valid;
      m_instr = bus.ifid_instr;
      m_npc   = bus.ifid_npc;
      m_rd1   = operand(bus.ifid_instr[25:21], bus.rdat1);
      m_rd2   = operand(bus.ifid_instr[20:16], bus.rdat2);
      m_wsel  = d.wsel;
      m_wen   = d.wen && bus.ifid_valid;
      m_mr    = d.memread && bus.ifid_valid;
    end
    @(posedge CLK); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] r1,
                       input logic [31:0] r2, input logic ew, input logic [4:0] ews,
                       input logic [31:0] ewd, input logic st, input logic fl);
    bus.ifid_valid = v;  bus.ifid_instr = instr; bus.ifid_npc = $urandom;
    bus.rdat1 = r1;      bus.rdat2 = r2;
    bus.exmem_wen = ew;  bus.exmem_wsel = ews;   bus.exmem_wdat = ewd;
    bus.ex_stall = st;   bus.flush = fl;
  endtask

  localparam logic [31:0] LW4 = {6'h23, 5'd2, 5'd4, 16'h0010};

  task automatic test_reset();
    nRST = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    model_reset();
    #1;
    tests_run++;
    if ({bus.idex_valid, bus.idex_wen, bus.idex_memread, bus.idex_wsel} !== 8'h0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %h want 0", {bus.idex_valid, bus.idex_wen, bus.idex_memread, bus.idex_wsel});
    end
    tests_run++;
    if (bus.bubble_cnt !== 16'h0) begin
      tests_failed++; $display("FAIL reset_cnt: got %h want 0", bus.bubble_cnt);
    end
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    drive(1'b1, rtype(5'd9, 5'd10, 5'd11, 6'h20), 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if ({bus.rsel1, bus.rsel2} !== {5'd9, 5'd10}) begin
      tests_failed++; $display("FAIL rsel: got %0d/%0d want 9/10", bus.rsel1, bus.rsel2);
    end
  endtask

  task automatic test_add();
    drive(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (bus.ifid_stall !== 1'b0) begin
      tests_failed++; $display("FAIL add_stall: got %b want 0", bus.ifid_stall);
    end
    tick();
    tests_run++;
    if ({bus.idex_valid, bus.idex_rdat1, bus.idex_rdat2, bus.idex_wsel, bus.idex_wen} !==
        {1'b1, 32'd5, 32'd7, 5'd3, 1'b1}) begin
      tests_failed++; $display("FAIL add_fields: got v%b %h %h w%0d e%b want v1 5 7 w3 e1",
        bus.idex_valid, bus.idex_rdat1, bus.idex_rdat2, bus.idex_wsel, bus.idex_wen);
    end
    tests_run++;
    if (bus.idex_npc !== m_npc) begin
      tests_failed++; $display("FAIL add_npc: got %h want %h", bus.idex_npc, m_npc);
    end
  endtask

  task automatic test_forward();
    drive(1'b1, rtype(5'd1, 5'd9, 5'd6, 6'h20), 32'h1111, 32'h0, 1'b1, 5'd1, 32'hDEAD, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (bus.idex_rdat1 !== 32'hDEAD) begin
      tests_failed++; $display("FAIL fwd_hit: got %h want dead", bus.idex_rdat1);
    end
    drive(1'b1, rtype(5'd1, 5'd9, 5'd6, 6'h20), 32'h1111, 32'h0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (bus.idex_rdat1 !== 32'h1111) begin
      tests_failed++; $display("FAIL fwd_r0: got %h want 1111", bus.idex_rdat1);
    end
  endtask

  task automatic test_load_use();
    int c0;
    c0 = m_cnt;
    drive(1'b1, LW4, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if ({bus.idex_memread, bus.idex_wsel} !== {1'b1, 5'd4}) begin
      tests_failed++; $display("FAIL lw_latch: got mr%b w%0d want mr1 w4", bus.idex_memread, bus.idex_wsel);
    end
    drive(1'b1, rtype(5'd4, 5'd4, 5'd5, 6'h20), 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (bus.ifid_stall !== 1'b1) begin
      tests_failed++; $display("FAIL lu_stall: got %b want 1", bus.ifid_stall);
    end
    tick();
    tests_run++;
    if ({bus.idex_valid, bus.bubble_cnt} !== {1'b0, 16'(c0 + 1)}) begin
      tests_failed++; $display("FAIL lu_bubble: got v%b cnt%0d want v0 cnt%0d", bus.idex_valid, bus.bubble_cnt, c0 + 1);
    end
    drive(1'b1, rtype(5'd4, 5'd4, 5'd5, 6'h20), 32'h0, 32'h0, 1'b1, 5'd4, 32'hABCD, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (bus.ifid_stall !== 1'b0) begin
      tests_failed++; $display("FAIL lu_release: got %b want 0", bus.ifid_stall);
    end
    tick();
    tests_run++;
    if ({bus.idex_valid, bus.idex_wsel, bus.idex_rdat1, bus.idex_rdat2} !== {1'b1, 5'd5, 32'hABCD, 32'hABCD}) begin
      tests_failed++; $display("FAIL lu_issue: got v%b w%0d %h %h want v1 w5 abcd abcd",
        bus.idex_valid, bus.idex_wsel, bus.idex_rdat1, bus.idex_rdat2);
    end
  endtask

  task automatic test_sw_j();
    int c0;
    drive(1'b1, LW4, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    c0 = m_cnt;
    drive(1'b1, itype(6'h2B, 5'd7, 5'd4, 16'h0), 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (bus.ifid_stall !== 1'b1) begin
      tests_failed++; $display("FAIL sw_stall: got %b want 1", bus.ifid_stall);
    end
    tick();
    tests_run++;
    if ({bus.idex_valid, bus.bubble_cnt} !== {1'b0, 16'(c0 + 1)}) begin
      tests_failed++; $display("FAIL sw_bubble: got v%b cnt%0d want v0 cnt%0d", bus.idex_valid, bus.bubble_cnt, c0 + 1);
    end
    drive(1'b1, LW4, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    c0 = m_cnt;
    drive(1'b1, {6'h02, 5'd0, 5'd4, 16'h0040}, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (bus.ifid_stall !== 1'b0) begin
      tests_failed++; $display("FAIL j_stall: got %b want 0", bus.ifid_stall);
    end
    tick();
    tests_run++;
    if ({bus.idex_valid, bus.idex_wen, bus.bubble_cnt} !== {1'b1, 1'b0, 16'(c0)}) begin
      tests_failed++; $display("FAIL j_issue: got v%b e%b cnt%0d want v1 e0 cnt%0d", bus.idex_valid, bus.idex_wen, bus.bubble_cnt, c0);
    end
  endtask

  task automatic test_flush_hazard();
    int c0;
    drive(1'b1, LW4, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    c0 = m_cnt;
    drive(1'b1, rtype(5'd4, 5'd1, 5'd5, 6'h20), 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    #1;
    tests_run++;
    if (bus.ifid_stall !== 1'b0) begin
      tests_failed++; $display("FAIL fl_stall: got %b want 0", bus.ifid_stall);
    end
    tick();
    tests_run++;
    if ({bus.idex_valid, bus.bubble_cnt} !== {1'b0, 16'(c0)}) begin
      tests_failed++; $display("FAIL fl_state: got v%b cnt%0d want v0 cnt%0d", bus.idex_valid, bus.bubble_cnt, c0);
    end
  endtask

  task automatic test_stall_hazard();
    int c0;
    drive(1'b1, LW4, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    c0 = m_cnt;
    drive(1'b1, rtype(5'd4, 5'd1, 5'd5, 6'h20), 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (bus.ifid_stall !== 1'b1) begin
      tests_failed++; $display("FAIL st_stall: got %b want 1", bus.ifid_stall);
    end
    tick();
    tests_run++;
    if ({bus.idex_valid, bus.idex_memread, bus.idex_instr, bus.bubble_cnt} !== {1'b1, 1'b1, LW4, 16'(c0)}) begin
      tests_failed++; $display("FAIL st_hold: got v%b mr%b %h cnt%0d want v1 mr1 %h cnt%0d",
        bus.idex_valid, bus.idex_memread, bus.idex_instr, bus.bubble_cnt, LW4, c0);
    end
  endtask

  task automatic test_reset_midrun();
    nRST = 1'b0;
    #1;
    tests_run++;
    if ({bus.idex_valid, bus.idex_instr, bus.idex_npc, bus.idex_rdat1, bus.idex_rdat2,
         bus.idex_wsel, bus.idex_wen, bus.idex_memread, bus.bubble_cnt} !== '0) begin
      tests_failed++; $display("FAIL async_reset: got v%b %h mr%b cnt%0d want all 0",
        bus.idex_valid, bus.idex_instr, bus.idex_memread, bus.bubble_cnt);
    end
    #1 nRST = 1'b1;
    model_reset();
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, LW4, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      tick();
      drive(1'b1, rtype(5'd4, 5'd4, 5'd5, 6'h20), 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      tick();
      tests_run++;
      if (bus_s.bubble_cnt !== 2'((i > 3) ? 3 : i)) begin
        tests_failed++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, bus_s.bubble_cnt, (i > 3) ? 3 : i);
      end
    end
    tests_run++;
    if (bus.bubble_cnt !== 16'd5) begin
      tests_failed++; $display("FAIL wide_cnt: got %0d want 5", bus.bubble_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [4:0]  a, b, c;
    for (int n = 0; n < 400; n++) begin
      a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       ins = rtype(a, b, c, 6'h20);
        1:       ins = rtype(a, b, c, 6'h08);
        2, 3:    ins = itype(6'h23, a, b, 16'($urandom));
        4:       ins = itype(6'h2B, a, b, 16'($urandom));
        5:       ins = itype(6'h04, a, b, 16'($urandom));
        6:       ins = itype(6'h05, a, b, 16'($urandom));
        7:       ins = {6'h02, a, b, 16'($urandom)};
        8:       ins = {6'h03, a, b, 16'($urandom)};
        default: ins = itype(6'h08, a, b, 16'($urandom));
      endcase
      drive($urandom_range(0, 9) != 0, ins, $urandom, $urandom, 1'($urandom),
            5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
      #1;
      tests_run++;
      if ({bus.rsel1, bus.rsel2, bus.ifid_stall} !== {ins[25:21], ins[20:16], exp_stall()}) begin
        tests_failed++; $display("FAIL rnd_comb@%0d: got %0d/%0d/%b want %0d/%0d/%b", n,
          bus.rsel1, bus.rsel2, bus.ifid_stall, ins[25:21], ins[20:16], exp_stall());
      end
      tick();
      tests_run++;
      if ({bus.idex_valid, bus.idex_instr, bus.idex_npc, bus.idex_rdat1, bus.idex_rdat2,
           bus.idex_wsel, bus.idex_wen, bus.idex_memread} !==
          {m_valid, m_instr, m_npc, m_rd1, m_rd2, m_wsel, m_wen, m_mr}) begin
        tests_failed++; $display("FAIL rnd_idex@%0d: got %h want %h", n,
          {bus.idex_valid, bus.idex_instr, bus.idex_npc, bus.idex_rdat1, bus.idex_rdat2,
           bus.idex_wsel, bus.idex_wen, bus.idex_memread},
          {m_valid, m_instr, m_npc, m_rd1, m_rd2, m_wsel, m_wen, m_mr});
      end
      tests_run++;
      if ({bus.bubble_cnt, bus_s.bubble_cnt} !== {16'(m_cnt), 2'(m_cnt_s)}) begin
        tests_failed++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", n,
          bus.bubble_cnt, bus_s.bubble_cnt, m_cnt, m_cnt_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_sw_j();
    test_flush_hazard();
    test_stall_hazard();
    test_reset_midrun();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
